// File: rtl/depatchifier_pkg.sv
// depatchifier_pkg
//   Shared definitions for the depatchifier block:
//   - state_e : 2-bit control state, encoded the same way as the patchifier
//               so both blocks can be driven from one controller.
//   - default image / patch dimensions.
//   - width helpers for the patch counter and the patch row/col indices.
package depatchifier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int DEF_CHANNEL_SIZE = 8;
  localparam int DEF_NUM_CHANNELS = 3;
  localparam int DEF_IMG_WIDTH    = 64;
  localparam int DEF_IMG_HEIGHT   = 64;
  localparam int DEF_PATCH_SIZE   = 4;

  // Width of a counter that must be able to hold the value 'total'.
  function automatic int count_width(input int total);
    return $clog2(total + 1);
  endfunction

  // Width of an index over 'n' entries (0 .. n-1), at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/depatchifier_if.sv
// depatchifier_if
//   Patch-stream handshake between a patch producer and the depatchifier.
//   patch_in    : one flattened patch, row-major inside the patch
//   patch_valid : producer has a patch this cycle
//   patch_ready : consumer accepts the patch this cycle
//   A beat transfers when patch_valid && patch_ready.
interface depatchifier_if #(
  parameter int PIXEL_WIDTH       = 24,
  parameter int PATCH_VECTOR_SIZE = 16
) ();

  logic [PIXEL_WIDTH-1:0] patch_in [PATCH_VECTOR_SIZE];
  logic                   patch_valid;
  logic                   patch_ready;

  modport master (
    output patch_in,
    output patch_valid,
    input  patch_ready
  );

  modport slave (
    input  patch_in,
    input  patch_valid,
    output patch_ready
  );

endinterface

// File: rtl/depatchifier_position_counter.sv
// patch_position_counter
//   Tracks the (row, col) position of the next patch in the image's patch
//   grid. Columns advance first; the column wraps at PATCHES_IN_ROW-1 and
//   carries into the row, and the row wraps at PATCH_ROWS-1 so the counter
//   returns to (0,0) after the last patch of a frame.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     clear      : return to (0,0)
//     inc        : advance to the next patch position
//     row, col   : current patch row / patch col
//     last       : current position is the final patch of the frame
module patch_position_counter
  import depatchifier_pkg::*;
#(
  parameter int PATCHES_IN_ROW = 16,
  parameter int PATCH_ROWS     = 16,
  parameter int ROW_W          = idx_width(PATCH_ROWS),
  parameter int COL_W          = idx_width(PATCHES_IN_ROW)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(PATCH_ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(PATCHES_IN_ROW - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             col_wrap;
  logic             row_wrap;

  assign col_wrap = (col_q == COL_MAX);
  assign row_wrap = (row_q == ROW_MAX);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_wrap ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = col_wrap && row_wrap;

endmodule

// File: rtl/depatchifier.sv
// depatchifier
//   Reassembles an image from flattened patches, one patch per handshake
//   beat. Patch k lands at patch row k / PATCHES_IN_ROW and patch col
//   k % PATCHES_IN_ROW; element p of a patch lands at
//   image[pr*PATCH_SIZE + p/PATCH_SIZE][pc*PATCH_SIZE + p%PATCH_SIZE].
//   Control is IDLE -> FILL -> DONE -> IDLE, identical to the patchifier.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     en           : start request, looked at only in IDLE
//     patch_if     : patch stream (slave side: patch_in/patch_valid in,
//                    patch_ready out; ready is high exactly in FILL)
//     patch_count  : patches accepted in the current frame
//     output_taken : consumer has taken the image, looked at only in DONE
//     state        : current control state
//     image        : registered reassembled image
module depatchifier
  import depatchifier_pkg::*;
#(
  parameter int CHANNEL_SIZE      = DEF_CHANNEL_SIZE,
  parameter int NUM_CHANNELS      = DEF_NUM_CHANNELS,
  parameter int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
  parameter int IMG_WIDTH         = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT        = DEF_IMG_HEIGHT,
  parameter int PATCH_SIZE        = DEF_PATCH_SIZE,
  parameter int PATCHES_IN_ROW    = IMG_HEIGHT / PATCH_SIZE,
  parameter int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
  parameter int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      en,
  depatchifier_if.slave                             patch_if,
  output logic [count_width(TOTAL_NUM_PATCHES)-1:0] patch_count,
  input  logic                                      output_taken,
  output state_e                                    state,
  output logic [PIXEL_WIDTH-1:0]                    image [IMG_WIDTH][IMG_HEIGHT]
);

  localparam int PATCH_ROWS = IMG_WIDTH / PATCH_SIZE;
  localparam int CNT_W      = count_width(TOTAL_NUM_PATCHES);
  localparam int ROW_W      = idx_width(PATCH_ROWS);
  localparam int COL_W      = idx_width(PATCHES_IN_ROW);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       patch_count_q, patch_count_d;
  logic [PIXEL_WIDTH-1:0] image_q [IMG_WIDTH][IMG_HEIGHT];
  logic [PIXEL_WIDTH-1:0] image_d [IMG_WIDTH][IMG_HEIGHT];

  logic             accept;
  logic             pos_clear;
  logic             pos_inc;
  logic             clear_image;
  logic [ROW_W-1:0] patch_row;
  logic [COL_W-1:0] patch_col;
  logic             last_patch;

  patch_position_counter #(
    .PATCHES_IN_ROW (PATCHES_IN_ROW),
    .PATCH_ROWS     (PATCH_ROWS)
  ) u_pos (
    .clk   (clk),
    .reset (reset),
    .clear (pos_clear),
    .inc   (pos_inc),
    .row   (patch_row),
    .col   (patch_col),
    .last  (last_patch)
  );

  assign patch_if.patch_ready = (state_q == ST_FILL);
  assign accept               = patch_if.patch_valid && (state_q == ST_FILL);

  // Control: next state, counter updates and image-clear request.
  always_comb begin
    state_d       = state_q;
    patch_count_d = patch_count_q;
    pos_clear     = 1'b0;
    pos_inc       = 1'b0;
    clear_image   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d       = ST_FILL;
          patch_count_d = '0;
          pos_clear     = 1'b1;
        end
      end
      ST_FILL: begin
        if (accept) begin
          patch_count_d = patch_count_q + CNT_W'(1);
          // The position counter wraps to (0,0) on its own after the last
          // patch, so no separate clear is needed on the way to DONE.
          pos_inc       = 1'b1;
          if (last_patch) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // output_taken outranks en here; en is only looked at in IDLE.
        if (output_taken) begin
          state_d       = ST_IDLE;
          patch_count_d = '0;
          clear_image   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scatter write: each pixel decides from constant coordinates whether it
  // belongs to the patch being accepted, so the patch element index is a
  // constant per pixel and only the patch row/col compare is dynamic.
  always_comb begin
    for (int r = 0; r < IMG_WIDTH; r++) begin
      for (int c = 0; c < IMG_HEIGHT; c++) begin
        image_d[r][c] = image_q[r][c];
        if (clear_image) begin
          image_d[r][c] = '0;
        end else if (accept &&
                     ((r / PATCH_SIZE) == int'(patch_row)) &&
                     ((c / PATCH_SIZE) == int'(patch_col))) begin
          image_d[r][c] =
            patch_if.patch_in[(r % PATCH_SIZE) * PATCH_SIZE + (c % PATCH_SIZE)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      patch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      patch_count_q <= patch_count_d;
    end
  end

  // NOTE: the image is a bank of flops, not a RAM, and must read as all
  // zero after reset, so it is reset explicitly like any other register.
  always_ff @(posedge clk) begin
    for (int r = 0; r < IMG_WIDTH; r++) begin
      for (int c = 0; c < IMG_HEIGHT; c++) begin
        if (reset) begin
          image_q[r][c] <= '0;
        end else begin
          image_q[r][c] <= image_d[r][c];
        end
      end
    end
  end

  assign state       = state_q;
  assign patch_count = patch_count_q;
  assign image       = image_q;

endmodule
